// File: rtl/inert_reader.sv
// inert_reader
//   Reads six gyro-rate bytes (pitch/roll/yaw, low then high) from the inertial
//   sensor through an external SPI master on every data-ready edge. It then
//   integrates each signed rate into a fixed-point attitude accumulator and
//   publishes the integer part with a one-cycle vld pulse.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a synchronised rising edge on INT
//   SEND  | wrt high for this single cycle, cmd already holds the address
//   WAIT  | waiting for done; capture resp into byte slot idx
//   INTEG | add the six captured rates into the accumulators
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   INT        sensor data-ready, asynchronous to clk
//   wrt        one-cycle pulse starting an SPI transaction
//   cmd[15:0]  SPI command {read bit, register address, 8'h00}
//   done       one-cycle pulse from the SPI master, resp valid
//   resp[7:0]  read byte returned by the SPI master
//   vld        one-cycle pulse, ptch/roll/yaw carry a new sample
//   ptch/roll/yaw[15:0]  integrated attitude, signed

module inert_reader #(
    parameter logic [6:0] BASE_ADDR = 7'h22,
    parameter int          FRAC      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [7:0]  resp,
    output logic        vld,
    output logic [15:0] ptch,
    output logic [15:0] roll,
    output logic [15:0] yaw
);

    localparam int ACC_W = 16 + FRAC;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, INTEG} state_t;

    state_t             state, state_nxt;
    logic               int_ff1, int_sync, int_prev;
    logic               int_rise;
    logic [2:0]         idx;
    logic [5:0][7:0]    rate_bytes;
    logic [ACC_W-1:0]   acc_p, acc_r, acc_y;

    function automatic logic [15:0] read_cmd(input logic [2:0] i);
        return {1'b1, 7'(BASE_ADDR + 7'(i)), 8'h00};
    endfunction

    function automatic logic [ACC_W-1:0] sext(input logic [15:0] r);
        return {{FRAC{r[15]}}, r};
    endfunction

    assign int_rise = int_sync & ~int_prev;

    always_comb begin
        state_nxt = state;
        wrt       = 1'b0;
        case (state)
            IDLE:  if (int_rise) state_nxt = SEND;
            SEND:  begin
                wrt       = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:  if (done) state_nxt = (idx == 3'd5) ? INTEG : SEND;
            INTEG: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            int_ff1    <= 1'b0;
            int_sync   <= 1'b0;
            int_prev   <= 1'b0;
            idx        <= 3'd0;
            cmd        <= 16'h0000;
            vld        <= 1'b0;
            rate_bytes <= '0;
            acc_p      <= '0;
            acc_r      <= '0;
            acc_y      <= '0;
        end else begin
            state    <= state_nxt;
            int_ff1  <= INT;
            int_sync <= int_ff1;
            int_prev <= int_sync;
            // vld follows INTEG by one cycle, so the accumulators are already updated
            vld      <= (state == INTEG);
            case (state)
                IDLE: begin
                    if (int_rise) begin
                        idx <= 3'd0;
                        cmd <= read_cmd(3'd0);
                    end
                end
                WAIT: begin
                    if (done) begin
                        rate_bytes[idx] <= resp;
                        if (idx != 3'd5) begin
                            idx <= 3'(idx + 3'd1);
                            cmd <= read_cmd(3'(idx + 3'd1));
                        end
                    end
                end
                INTEG: begin
                    // two's complement wrap is intended; no saturation
                    acc_p <= acc_p + sext({rate_bytes[1], rate_bytes[0]});
                    acc_r <= acc_r + sext({rate_bytes[3], rate_bytes[2]});
                    acc_y <= acc_y + sext({rate_bytes[5], rate_bytes[4]});
                end
                default: ;
            endcase
        end
    end

    assign ptch = acc_p[ACC_W-1:FRAC];
    assign roll = acc_r[ACC_W-1:FRAC];
    assign yaw  = acc_y[ACC_W-1:FRAC];

endmodule

// File: tb/tb_inert_reader.sv
module tb_inert_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        INT = 1'b0;
    logic        wrt;
    logic [15:0] cmd;
    logic        done = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        vld;
    logic [15:0] ptch, roll, yaw;

    int total = 0;
    int bad   = 0;

    int          wrt_cnt = 0;
    int          vld_cnt = 0;
    int          wrt_dbl = 0;
    logic        wrt_prev = 1'b0;
    logic [15:0] cmd_q[$];
    logic [7:0]  resp_tab [6];
    bit          spi_mute = 1'b0;
    int          spi_idx;
    int          spi_dly;

    inert_reader #(.BASE_ADDR(7'h22), .FRAC(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .INT  (INT),
        .wrt  (wrt),
        .cmd  (cmd),
        .done (done),
        .resp (resp),
        .vld  (vld),
        .ptch (ptch),
        .roll (roll),
        .yaw  (yaw)
    );

    always #5 clk = ~clk;

    // bus monitor
    always @(negedge clk) begin
        if (wrt === 1'b1) begin
            wrt_cnt++;
            cmd_q.push_back(cmd);
            if (wrt_prev === 1'b1) wrt_dbl++;
        end
        if (vld === 1'b1) vld_cnt++;
        wrt_prev = wrt;
    end

    // SPI master model: answers each wrt 10-40 clocks later with the table byte
    initial begin
        forever begin
            @(negedge clk);
            while (wrt === 1'b1) begin
                spi_idx = int'(cmd[14:8]) - 'h22;
                spi_dly = $urandom_range(40, 10);
                repeat (spi_dly) @(negedge clk);
                if (!spi_mute) begin
                    resp = (spi_idx >= 0 && spi_idx < 6) ? resp_tab[spi_idx] : 8'h00;
                    done = 1'b1;
                    @(negedge clk);
                    done = 1'b0;
                    resp = 8'h00;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        INT = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_sample(input logic [47:0] b, output bit ok);
        int v0;
        v0 = vld_cnt;
        for (int k = 0; k < 6; k++) resp_tab[k] = b[8*k +: 8];
        @(negedge clk);
        #3 INT = 1'b1;
        repeat (4) @(negedge clk);
        INT = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (vld_cnt > v0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int nz;
        do_reset();
        nz = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (wrt !== 1'b0 || vld !== 1'b0 || cmd !== 16'h0000 ||
                ptch !== 16'h0 || roll !== 16'h0 || yaw !== 16'h0) nz++;
        end
        total++;
        if (nz !== 0) begin
            bad++;
            $display("FAIL reset_quiet: nonzero cycles=%0d required 0", nz);
        end
        total++;
        if (wrt_cnt !== 0 || vld_cnt !== 0) begin
            bad++;
            $display("FAIL reset_counts: wrt=%0d vld=%0d required 0/0", wrt_cnt, vld_cnt);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int w0, v0;
        logic [15:0] exp_cmd [6];
        do_reset();
        cmd_q.delete();
        w0 = wrt_cnt;
        v0 = vld_cnt;
        for (int k = 0; k < 6; k++) exp_cmd[k] = 16'hA200 + 16'(k * 16'h0100);
        run_sample(48'hFFF0_0020_0010, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_timeout: vld seen=0 required 1");
        end
        total++;
        if (wrt_cnt - w0 !== 6) begin
            bad++;
            $display("FAIL basic_wrt_count: got %0d required 6", wrt_cnt - w0);
        end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (k >= cmd_q.size() || cmd_q[k] !== exp_cmd[k]) begin
                bad++;
                $display("FAIL basic_cmd%0d: got %h required %h", k,
                         (k < cmd_q.size()) ? cmd_q[k] : 16'hxxxx, exp_cmd[k]);
            end
        end
        total++;
        if (vld_cnt - v0 !== 1) begin
            bad++;
            $display("FAIL basic_vld_count: got %0d required 1", vld_cnt - v0);
        end
        total++;
        if (ptch !== 16'h0001 || roll !== 16'h0002 || yaw !== 16'hFFFF) begin
            bad++;
            $display("FAIL basic_outputs: got %h %h %h required 0001 0002 ffff", ptch, roll, yaw);
        end
        total++;
        if (wrt_dbl !== 0) begin
            bad++;
            $display("FAIL wrt_back_to_back: got %0d required 0", wrt_dbl);
        end
        total++;
        if (cmd !== 16'hA700) begin
            bad++;
            $display("FAIL cmd_hold: got %h required a700", cmd);
        end
    endtask

    task automatic test_frac_accum();
        bit ok;
        int v0, to;
        logic [15:0] exp_p;
        do_reset();
        v0 = vld_cnt;
        to = 0;
        for (int i = 1; i <= 16; i++) begin
            run_sample(48'h0000_0000_0001, ok);
            if (!ok) to++;
            exp_p = (i == 16) ? 16'h0001 : 16'h0000;
            total++;
            if (ptch !== exp_p) begin
                bad++;
                $display("FAIL frac_ptch_s%0d: got %h required %h", i, ptch, exp_p);
            end
        end
        total++;
        if (to !== 0 || vld_cnt - v0 !== 16) begin
            bad++;
            $display("FAIL frac_vld_count: got %0d (timeouts %0d) required 16", vld_cnt - v0, to);
        end
    endtask

    task automatic test_int_during_wait();
        int w0, v0, c;
        bit reached, ok;
        do_reset();
        w0 = wrt_cnt;
        v0 = vld_cnt;
        for (int k = 0; k < 6; k++) resp_tab[k] = 8'h11 * k;
        @(negedge clk);
        #3 INT = 1'b1;
        repeat (4) @(negedge clk);
        INT = 1'b0;
        reached = 1'b0;
        for (c = 0; c < 400; c++) begin
            @(negedge clk);
            if (wrt_cnt - w0 >= 3) begin
                reached = 1'b1;
                break;
            end
        end
        #3 INT = 1'b1;
        repeat (4) @(negedge clk);
        INT = 1'b0;
        ok = 1'b0;
        for (c = 0; c < 800; c++) begin
            @(negedge clk);
            if (vld_cnt > v0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (300) @(negedge clk);
        total++;
        if (!reached || !ok) begin
            bad++;
            $display("FAIL retrig_timeout: reached=%0d vld=%0d required 1/1", reached, ok);
        end
        total++;
        if (wrt_cnt - w0 !== 6 || vld_cnt - v0 !== 1) begin
            bad++;
            $display("FAIL retrig_counts: wrt=%0d vld=%0d required 6/1", wrt_cnt - w0, vld_cnt - v0);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int to;
        do_reset();
        to = 0;
        for (int i = 1; i <= 17; i++) begin
            run_sample(48'h0000_0000_7FFF, ok);
            if (!ok) to++;
            if (i == 1) begin
                total++;
                if (ptch !== 16'h07FF) begin
                    bad++;
                    $display("FAIL wrap_s1: got %h required 07ff", ptch);
                end
            end
            if (i == 16) begin
                total++;
                if (ptch !== 16'h7FFF) begin
                    bad++;
                    $display("FAIL wrap_s16: got %h required 7fff", ptch);
                end
            end
        end
        total++;
        if (ptch !== 16'h87FE || to !== 0) begin
            bad++;
            $display("FAIL wrap_s17: got %h (timeouts %0d) required 87fe", ptch, to);
        end
    endtask

    task automatic test_reset_mid();
        int w0, v0, c;
        bit ok;
        do_reset();
        w0 = wrt_cnt;
        v0 = vld_cnt;
        spi_mute = 1'b1;
        @(negedge clk);
        #3 INT = 1'b1;
        repeat (4) @(negedge clk);
        INT = 1'b0;
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            if (wrt_cnt - w0 >= 1) break;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        resp = 8'h55;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        resp = 8'h00;
        repeat (60) @(negedge clk);
        total++;
        if (vld_cnt - v0 !== 0) begin
            bad++;
            $display("FAIL abort_vld: got %0d required 0", vld_cnt - v0);
        end
        total++;
        if (ptch !== 16'h0 || roll !== 16'h0 || yaw !== 16'h0 || cmd !== 16'h0) begin
            bad++;
            $display("FAIL abort_outputs: got %h %h %h cmd %h required all 0", ptch, roll, yaw, cmd);
        end
        total++;
        if (wrt_cnt - w0 !== 1) begin
            bad++;
            $display("FAIL abort_wrt: got %0d required 1", wrt_cnt - w0);
        end
        spi_mute = 1'b0;
        w0 = wrt_cnt;
        v0 = vld_cnt;
        run_sample(48'hFFF0_0020_0010, ok);
        total++;
        if (!ok || wrt_cnt - w0 !== 6 || vld_cnt - v0 !== 1) begin
            bad++;
            $display("FAIL recover_counts: wrt=%0d vld=%0d required 6/1", wrt_cnt - w0, vld_cnt - v0);
        end
        total++;
        if (ptch !== 16'h0001 || roll !== 16'h0002 || yaw !== 16'hFFFF) begin
            bad++;
            $display("FAIL recover_outputs: got %h %h %h required 0001 0002 ffff", ptch, roll, yaw);
        end
    endtask

    initial begin
        for (int k = 0; k < 6; k++) resp_tab[k] = 8'h00;
        test_reset();
        test_basic();
        test_frac_accum();
        test_int_during_wait();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
